// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch (I) and load/store (D).
// One outstanding transaction, D priority with an I anti-starvation guard,
// and a no-ack timeout that returns an error to the requester.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_I = 2'd1,
        S_WAIT_D = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        busy_q, busy_d;
    logic        w_streak_sat;

    // Byte lanes within a word are chosen by d_wstrb, so the low address bits are dropped.
    logic unused_d_addr_lsbs;
    assign unused_d_addr_lsbs = ^d_addr[1:0];

    assign w_streak_sat = (streak_q == STREAK_MAX);

    // Next-state and registered-output computation; everything holds unless changed.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        if_ack_d    = 1'b0;
        if_err_d    = if_err_q;
        if_rdata_d  = if_rdata_q;
        d_ack_d     = 1'b0;
        d_err_d     = d_err_q;
        d_rdata_d   = d_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        case (state_q)
            S_IDLE: begin
                if (d_req && !(if_req && w_streak_sat)) begin
                    state_d     = S_WAIT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = {d_addr[31:2], 2'b00};
                    mem_wdata_d = d_wdata;
                    mem_wstrb_d = d_we ? d_wstrb : 4'b0000;
                    tmo_d       = '0;
                    // Only count D grants that actually made I wait.
                    streak_d    = if_req ? streak_q + SW'(1) : '0;
                end else if (if_req) begin
                    streak_d = '0;
                    if (if_addr[1:0] != 2'b00) begin
                        // Misaligned fetch is answered locally without touching memory.
                        state_d    = S_RESP;
                        if_ack_d   = 1'b1;
                        if_err_d   = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        state_d     = S_WAIT_I;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = 4'b0000;
                        tmo_d       = '0;
                    end
                end
            end
            S_WAIT_I, S_WAIT_D: begin
                if (mem_ack) begin
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    if (state_q == S_WAIT_I) begin
                        if_ack_d   = 1'b1;
                        if_err_d   = 1'b0;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b0;
                        d_rdata_d = mem_we_q ? 32'h0 : mem_rdata;
                    end
                end else if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                    state_d   = S_RESP;
                    mem_req_d = 1'b0;
                    if (state_q == S_WAIT_I) begin
                        if_ack_d   = 1'b1;
                        if_err_d   = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RESP: begin
                // Acks default low here, so the response pulse lasts one cycle.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            streak_q    <= '0;
            tmo_q       <= '0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'b0000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            busy_q      <= busy_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed self-checking bench for mem_port_arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Expected grant side for ten back-to-back transactions with both requesting (1 = I).
    logic exp_is_i [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int cnt;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_if_ack", {31'b0, if_ack}, 32'd0);
        chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        tick();

        // Aligned fetch
        if_req = 1'b1; if_addr = 32'h100;
        tick();
        chk("f_mem_req", {31'b0, mem_req}, 32'd1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we", {31'b0, mem_we}, 32'd0);
        chk("f_busy", {31'b0, busy}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h00500093;
        tick();
        mem_ack = 1'b0;
        chk("f_if_ack", {31'b0, if_ack}, 32'd1);
        chk("f_if_rdata", if_rdata, 32'h00500093);
        chk("f_if_err", {31'b0, if_err}, 32'd0);
        chk("f_mem_req_drop", {31'b0, mem_req}, 32'd0);
        chk("f_d_ack", {31'b0, d_ack}, 32'd0);
        tick();
        chk("f_if_ack_pulse", {31'b0, if_ack}, 32'd0);
        chk("f_no_regrant", {31'b0, mem_req}, 32'd0);
        chk("f_busy_idle", {31'b0, busy}, 32'd0);
        if_req = 1'b0;
        tick();

        // Store with unaligned address
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h203; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b1000;
        tick();
        chk("s_mem_addr", mem_addr, 32'h200);
        chk("s_mem_we", {31'b0, mem_we}, 32'd1);
        chk("s_mem_wstrb", {28'b0, mem_wstrb}, 32'h8);
        chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0; d_req = 1'b0;
        chk("s_d_ack", {31'b0, d_ack}, 32'd1);
        chk("s_d_rdata", d_rdata, 32'd0);
        chk("s_d_err", {31'b0, d_err}, 32'd0);
        chk("s_if_ack", {31'b0, if_ack}, 32'd0);
        tick();
        chk("s_d_ack_pulse", {31'b0, d_ack}, 32'd0);

        // Load: read strobes forced to zero
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_wstrb = 4'b1111;
        tick();
        chk("l_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
        chk("l_mem_we", {31'b0, mem_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0; d_req = 1'b0;
        chk("l_d_rdata", d_rdata, 32'hCAFEF00D);
        tick();

        // Both requesting continuously; memory acks immediately
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        mem_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            mem_rdata = 32'h1000 + k;
            tick();
            chk($sformatf("arb%0d_mem_addr", k), mem_addr, exp_is_i[k] ? 32'h100 : 32'h300);
            tick();
            chk($sformatf("arb%0d_if_ack", k), {31'b0, if_ack}, {31'b0, exp_is_i[k]});
            chk($sformatf("arb%0d_d_ack", k), {31'b0, d_ack}, {31'b0, !exp_is_i[k]});
            if (exp_is_i[k]) chk($sformatf("arb%0d_if_rdata", k), if_rdata, 32'h1000 + k);
            else chk($sformatf("arb%0d_d_rdata", k), d_rdata, 32'h1000 + k);
            tick();
        end
        if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Timeout on a load with no memory response
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; mem_rdata = 32'hFFFF0000;
        tick();
        cnt = 0;
        while (mem_req === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
        chk("t_mem_req_cycles", cnt, 32'd64);
        chk("t_d_ack", {31'b0, d_ack}, 32'd1);
        chk("t_d_err", {31'b0, d_err}, 32'd1);
        chk("t_d_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        tick();
        chk("t_d_ack_pulse", {31'b0, d_ack}, 32'd0);
        mem_ack = 1'b1;
        tick(); tick();
        mem_ack = 1'b0;
        chk("t_stray_d_ack", {31'b0, d_ack}, 32'd0);
        chk("t_stray_if_ack", {31'b0, if_ack}, 32'd0);
        chk("t_stray_busy", {31'b0, busy}, 32'd0);

        // Misaligned fetch
        if_req = 1'b1; if_addr = 32'h102;
        tick();
        chk("m_if_ack", {31'b0, if_ack}, 32'd1);
        chk("m_if_err", {31'b0, if_err}, 32'd1);
        chk("m_if_rdata", if_rdata, 32'd0);
        chk("m_mem_req", {31'b0, mem_req}, 32'd0);
        if_req = 1'b0;
        tick();
        chk("m_if_ack_pulse", {31'b0, if_ack}, 32'd0);
        chk("m_mem_req2", {31'b0, mem_req}, 32'd0);

        // Asynchronous reset in the middle of WAIT_D, followed by a late ack
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'h55; d_wstrb = 4'b0001;
        tick();
        chk("r_mem_req_before", {31'b0, mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("r_async_mem_req", {31'b0, mem_req}, 32'd0);
        chk("r_async_busy", {31'b0, busy}, 32'd0);
        chk("r_async_mem_addr", mem_addr, 32'd0);
        d_req = 1'b0;
        tick();
        rst = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("r_late_d_ack", {31'b0, d_ack}, 32'd0);
        chk("r_late_mem_req", {31'b0, mem_req}, 32'd0);
        chk("r_late_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("r_late_d_ack2", {31'b0, d_ack}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
